dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, lane count and default latency.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LANES       = 4;
  localparam int LATENCY_DEF = 2;
  localparam int CNT_W       = 4;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide single-port RAM with per-byte write enables.
// Writes on the rising edge; the read port is combinational.
module dmem_array
  import mem_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [LANES-1:0]       be,
  input  logic [INDEX_WIDTH-1:0] idx,
  input  logic [8*LANES-1:0]     wdata,
  output logic [8*LANES-1:0]     rdata
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  logic [8*LANES-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) begin
        if (be[k]) begin
          mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one transaction in flight,
// fixed response latency, misaligned accesses flagged.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = LATENCY_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [LANES-1:0]         req_be_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_err_o
);

  localparam int IW = ADDRESS_WIDTH - 2;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LATENCY - 1);
  localparam logic ONE_CYCLE = (LATENCY == 1);

  state_t state;
  logic [CNT_W-1:0] cnt;

  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [LANES-1:0]         be_q;

  logic                     in_idle;
  logic                     accept;
  logic                     enter_resp;
  logic                     cur_we;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]    cur_wdata;
  logic [LANES-1:0]         cur_be;
  logic                     bad;
  logic                     ram_we;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  assign in_idle = (state == IDLE);
  assign accept  = req_valid_i & in_idle;

  // With single-cycle latency the access uses the live request.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (in_idle) begin
      cur_we    = req_we_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
      cur_be    = req_be_i;
    end
  end

  always_comb begin
    enter_resp = 1'b0;
    unique case (1'b1)
      accept:             enter_resp = ONE_CYCLE;
      (state == WAIT):    enter_resp = (cnt == LAST);
      default:            enter_resp = 1'b0;
    endcase
  end

  assign bad    = misaligned(cur_addr[1:0]);
  assign ram_we = rst & enter_resp & cur_we & ~bad;

  dmem_array #(
    .INDEX_WIDTH (IW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .be    (cur_be),
    .idx   (cur_addr[ADDRESS_WIDTH-1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            cnt     <= '0;
            state   <= ONE_CYCLE ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_err_o   <= bad;
        rsp_rdata_o <= (bad | cur_we) ? '0 : ram_rdata;
      end
    end
  end

  assign req_ready_o = in_idle;
  assign rsp_valid_o = (state == RESP);

endmodule
